bus_arbiter: RTL

//   Shares one memory/slave port between NUM_CLIENTS bus clients using rq/ack handshakes.

---
 rtl/bus_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/bus_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter slice.
//   state_t : arbiter FSM encoding (IDLE / ACCESS / DONE, 2 bits)
//   clog2   : ceiling log2 used to size the grant index and timeout counter;
//             never returns less than 1 so a 1-bit field is the minimum width.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req     : per-client request vector
//   ptr     : index with highest priority this round
//   gnt_idx : first set request at or after ptr, wrapping cyclically
//   any_req : at least one request is set (gnt_idx is only meaningful then)
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any_req
);

    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;
    logic          hi_found;
    logic          lo_found;

    // Scanning downward leaves the lowest matching index in each candidate:
    // hi_* is the lowest request at or above ptr, lo_* the lowest overall,
    // which is the wrap-around winner when nothing sits at or above ptr.
    always_comb begin
        hi_idx   = '0;
        lo_idx   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_idx   = IW'(j);
                lo_found = 1'b1;
                if (IW'(j) >= ptr) begin
                    hi_idx   = IW'(j);
                    hi_found = 1'b1;
                end
            end
        end
        any_req = lo_found;
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_CLIENTS requesters.
// One single-beat read or write is in flight at a time.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   rq, wr_ni           : per-client request (held until ack) and 1=write/0=read
//   address, dataW      : flattened per-client address / write data (client i at i*W)
//   ack                 : one-hot, one-cycle completion pulse
//   dataR               : read data, broadcast, valid during ack
//   err                 : one-cycle pulse with ack when the slave timed out
//   mem_en/mem_wr       : slave strobe (held until mem_rdy) and write enable
//   mem_addr/mem_wdata  : slave address / write data latched at grant
//   mem_rdata/mem_rdy   : slave read data and one-cycle completion
// Handshake: a client raises rq and keeps it up until it sees its ack bit; the
// slave sees mem_en held high until it returns a single mem_rdy cycle.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_CLIENTS = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            rq,
    input  logic [NUM_CLIENTS-1:0]            wr_ni,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]             dataR,
    output logic                              err,
    output logic                              mem_en,
    output logic                              mem_wr,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic [DATA_WIDTH-1:0]             mem_rdata,
    input  logic                              mem_rdy
);

    localparam int IW = clog2(NUM_CLIENTS);
    localparam int CW = clog2(TIMEOUT + 1);
    // ACCESS lasts at most TIMEOUT cycles: the counter reads 0 in the first one.
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    state_t                state;
    state_t                next_state;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         grant;
    logic [IW-1:0]         gnt_idx;
    logic                  any_req;
    logic                  lat_wr;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] data_r;
    logic [CW-1:0]         cnt;
    logic                  err_flag;
    logic                  timed_out;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_rr (
        .req     (rq),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // Mux the winning client's request fields out of the flattened buses.
    always_comb begin
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            if (gnt_idx == IW'(j)) begin
                sel_wr    = wr_ni[j];
                sel_addr  = address[j*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = dataW[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        next_state = state;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) next_state = ACCESS;
            end
            ACCESS: begin
                if (mem_rdy) begin
                    next_state = DONE;
                end else if (cnt == TMO_LAST) begin
                    timed_out  = 1'b1;
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            data_r    <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant     <= gnt_idx;
                        lat_wr    <= sel_wr;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        cnt       <= '0;
                        err_flag  <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (mem_rdy) begin
                        if (!lat_wr) data_r <= mem_rdata;
                    end else if (timed_out) begin
                        err_flag <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    // The client just served drops to lowest priority.
                    ptr <= (grant == IW'(NUM_CLIENTS - 1)) ? '0 : grant + IW'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        for (int j = 0; j < NUM_CLIENTS; j++) begin
            ack[j] = (state == DONE) && (grant == IW'(j));
        end
    end

    assign err       = (state == DONE) && err_flag;
    assign dataR     = data_r;
    assign mem_en    = (state == ACCESS);
    assign mem_wr    = lat_wr;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

endmodule
